commit_trace_buffer: RTL and testbench
======================================

COMMIT_TRACE_BUFFER -- requirements
Module: commit_trace_buffer

Interface
REQ-001 SHALL have parameter XLEN, default 64, datapath/register width (32 or 64).
REQ-002 SHALL have parameter NR_GPR, default 32, shadow GPR count (16 for RV32E, 32 otherwise).
REQ-003 SHALL have parameter DEPTH, default 8, trace FIFO entries; power of two, >=2.
REQ-004 clk  in  1  sole clock; all state updates on rising edge.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 commit_valid  in  1  one instruction retires this cycle.
REQ-007 commit_pc  in  XLEN  PC of retiring instruction.
REQ-008 commit_inst  in  32  instruction word.
REQ-009 commit_rd_wen / commit_rd / commit_rd_wdata  in  1 / log2(NR_GPR) / XLEN  destination write.
REQ-010 commit_is_break  in  1  retiring instruction is ebreak.
REQ-011 trace_valid / trace_ready  out / in  1 / 1  trace pop handshake.
REQ-012 trace_pc, trace_inst, trace_wen, trace_rd, trace_wdata  out  XLEN, 32, 1, log2(NR_GPR), XLEN  FIFO head fields.
REQ-013 gpr_raddr  in  log2(NR_GPR); gpr_rdata  out  XLEN  combinational shadow-GPR read.
REQ-014 halt  out  1; exit_code  out  XLEN; instret  out  64; overflow  out  1.

Function
REQ-015 Shadow GPR file SHALL update on commit_valid && commit_rd_wen && commit_rd!=0; entry 0 SHALL always read 0.
REQ-016 gpr_rdata SHALL reflect writes from the previous edge (no same-cycle bypass).
REQ-017 Each accepted commit SHALL push {pc, inst, wen, rd, wdata} into the FIFO; trace_valid SHALL rise one cycle after the push.
REQ-018 Pop SHALL occur on trace_valid && trace_ready; outputs SHALL come directly from head entry (registered storage, no combinational path from commit_*).
REQ-019 Simultaneous push and pop when full SHALL succeed with count unchanged; when empty, push only (no bypass).
REQ-020 Push when full without a same-cycle pop SHALL drop the new entry and set overflow (sticky until reset); shadow GPR and instret still update.
REQ-021 Pointers SHALL be log2(DEPTH)+1 bits, wrapping modulo 2*DEPTH; full = MSBs differ, low bits equal.
REQ-022 instret SHALL increment by 1 per commit_valid in RUN, saturating at 2^64-1.
REQ-023 FSM states RUN, DRAIN, HALTED.
REQ-024 RUN -> DRAIN on commit_valid && commit_is_break; the ebreak is itself pushed and counted; exit_code SHALL latch shadow GPR a0 (index 10) as of that edge (pre-write value if ebreak writes a0 -- it does not).
REQ-025 In DRAIN and HALTED further commits SHALL be ignored (no push, no GPR write, no count).
REQ-026 DRAIN -> HALTED when FIFO empty; halt SHALL be asserted in HALTED only, held until reset.
REQ-027 commit_is_break without commit_valid SHALL be ignored.

Reset
REQ-028 On rst: FIFO empty, trace_valid=0, overflow=0, halt=0, exit_code=0, instret=0, all shadow GPRs=0, FSM=RUN; trace data outputs don't-care while trace_valid=0.
REQ-029 rst asserted mid-drain SHALL discard FIFO contents and return to RUN on the next edge; rst takes priority over all events.

Structure
REQ-030 Shared package SHALL hold the FSM state enum, the trace-entry struct, and the a0 index constant (10).
REQ-031 FIFO storage and pointers SHALL be one sub-module, trace_fifo (parameters WIDTH, DEPTH); shadow GPR and FSM stay in top.

Verification
REQ-032 Reset, then commit pc=0x80000000 inst=0x00500513 rd=10 wdata=5 -> next cycle trace_valid=1, trace_pc=0x80000000; gpr_raddr=10 gives 5; instret=1.
REQ-033 DEPTH=8, trace_ready=0, 9 commits -> first 8 stored, overflow=1 after 9th, instret=9; 8 pops return entries in order.
REQ-034 Full FIFO, trace_ready=1 with commit same cycle -> count stays 8, no overflow.
REQ-035 a0=0x2A, ebreak committed with 3 entries queued -> state DRAIN, 4 pops, halt=1 the cycle after FIFO empty, exit_code=0x2A; later commits ignored.
REQ-036 Write rd=0 wdata=0xFFFF -> gpr_rdata(0)=0; trace entry still records wen=1 rd=0.
REQ-037 rst pulsed during DRAIN -> trace_valid=0, halt=0, instret=0, FSM RUN; new commit accepted normally.

Source files
------------

// File: rtl/commit_trace_buffer_pkg.sv
// rtl/commit_trace_buffer_pkg.sv - shared types and constants for the commit trace buffer
package commit_trace_buffer_pkg;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_HALTED = 2'd2
  } ctb_state_t;

  // Sized for the widest configuration; narrower builds zero-extend on push and slice on pop.
  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] inst;
    logic        wen;
    logic [4:0]  rd;
    logic [63:0] wdata;
  } trace_entry_t;

  localparam int A0_IDX = 10;

endpackage

// File: rtl/commit_trace_buffer_if.sv
// rtl/commit_trace_buffer_if.sv - commit, trace-pop, shadow-GPR and status signals
interface commit_trace_buffer_if #(
  parameter int XLEN   = 64,
  parameter int NR_GPR = 32
);
  localparam int RW = $clog2(NR_GPR);

  logic            commit_valid;
  logic [XLEN-1:0] commit_pc;
  logic [31:0]     commit_inst;
  logic            commit_rd_wen;
  logic [RW-1:0]   commit_rd;
  logic [XLEN-1:0] commit_rd_wdata;
  logic            commit_is_break;

  logic            trace_valid;
  logic            trace_ready;
  logic [XLEN-1:0] trace_pc;
  logic [31:0]     trace_inst;
  logic            trace_wen;
  logic [RW-1:0]   trace_rd;
  logic [XLEN-1:0] trace_wdata;

  logic [RW-1:0]   gpr_raddr;
  logic [XLEN-1:0] gpr_rdata;

  logic            halt;
  logic [XLEN-1:0] exit_code;
  logic [63:0]     instret;
  logic            overflow;

  modport master (
    output commit_valid, commit_pc, commit_inst, commit_rd_wen, commit_rd,
           commit_rd_wdata, commit_is_break, trace_ready, gpr_raddr,
    input  trace_valid, trace_pc, trace_inst, trace_wen, trace_rd, trace_wdata,
           gpr_rdata, halt, exit_code, instret, overflow
  );

  modport slave (
    input  commit_valid, commit_pc, commit_inst, commit_rd_wen, commit_rd,
           commit_rd_wdata, commit_is_break, trace_ready, gpr_raddr,
    output trace_valid, trace_pc, trace_inst, trace_wen, trace_rd, trace_wdata,
           gpr_rdata, halt, exit_code, instret, overflow
  );

endinterface

// File: rtl/commit_trace_buffer_trace_fifo.sv
// rtl/commit_trace_buffer_trace_fifo.sv - registered trace FIFO with wrap-bit pointers
module trace_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_rdata,
  output logic             o_empty,
  output logic             o_full
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wptr;
  logic [AW:0]      r_rptr;
  logic             w_do_pop;
  logic             w_do_push;

  assign o_empty   = (r_wptr == r_rptr);
  assign o_full    = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign w_do_pop  = i_pop && !o_empty;
  // A pop frees the head slot on the same edge, so a full FIFO can still take a push.
  assign w_do_push = i_push && (!o_full || w_do_pop);
  assign o_rdata   = r_mem[r_rptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_wptr[AW-1:0]] <= i_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_do_push) r_wptr <= r_wptr + 1'b1;
      if (w_do_pop)  r_rptr <= r_rptr + 1'b1;
    end
  end

endmodule

// File: rtl/commit_trace_buffer.sv
// rtl/commit_trace_buffer.sv - retired-instruction trace FIFO, shadow GPRs and ebreak halt FSM
module commit_trace_buffer
  import commit_trace_buffer_pkg::*;
#(
  parameter int XLEN   = 64,
  parameter int NR_GPR = 32,
  parameter int DEPTH  = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  commit_trace_buffer_if.slave  bus
);
  localparam int            RW   = $clog2(NR_GPR);
  localparam logic [RW-1:0] W_A0 = RW'(A0_IDX);

  ctb_state_t      r_state;
  logic [XLEN-1:0] r_gpr [NR_GPR];
  logic [63:0]     r_instret;
  logic            r_overflow;
  logic            r_halt;
  logic [XLEN-1:0] r_exit_code;

  logic            w_commit;
  logic            w_empty;
  logic            w_full;
  logic            w_pop;
  trace_entry_t    w_push_entry;
  trace_entry_t    w_head;

  assign w_commit = bus.commit_valid && (r_state == ST_RUN);
  assign w_pop    = bus.trace_ready && !w_empty;

  always_comb begin
    w_push_entry       = '0;
    w_push_entry.pc    = 64'(bus.commit_pc);
    w_push_entry.inst  = bus.commit_inst;
    w_push_entry.wen   = bus.commit_rd_wen;
    w_push_entry.rd    = 5'(bus.commit_rd);
    w_push_entry.wdata = 64'(bus.commit_rd_wdata);
  end

  trace_fifo #(
    .WIDTH ($bits(trace_entry_t)),
    .DEPTH (DEPTH)
  ) u_trace_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_commit),
    .i_wdata (w_push_entry),
    .i_pop   (bus.trace_ready),
    .o_rdata (w_head),
    .o_empty (w_empty),
    .o_full  (w_full)
  );

  assign bus.trace_valid = !w_empty;
  assign bus.trace_pc    = w_head.pc[XLEN-1:0];
  assign bus.trace_inst  = w_head.inst;
  assign bus.trace_wen   = w_head.wen;
  assign bus.trace_rd    = w_head.rd[RW-1:0];
  assign bus.trace_wdata = w_head.wdata[XLEN-1:0];

  assign bus.gpr_rdata = (bus.gpr_raddr == '0) ? '0 : r_gpr[bus.gpr_raddr];
  assign bus.halt      = r_halt;
  assign bus.exit_code = r_exit_code;
  assign bus.instret   = r_instret;
  assign bus.overflow  = r_overflow;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NR_GPR; i++) r_gpr[i] <= '0;
      r_instret  <= '0;
      r_overflow <= 1'b0;
    end else if (w_commit) begin
      if (bus.commit_rd_wen && (bus.commit_rd != '0)) r_gpr[bus.commit_rd] <= bus.commit_rd_wdata;
      if (r_instret != '1) r_instret <= r_instret + 64'd1;
      if (w_full && !w_pop) r_overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_RUN;
      r_halt      <= 1'b0;
      r_exit_code <= '0;
    end else begin
      case (r_state)
        ST_RUN: begin
          // a0 is read before this edge's GPR write lands, giving the pre-ebreak value.
          if (w_commit && bus.commit_is_break) begin
            r_state     <= ST_DRAIN;
            r_exit_code <= r_gpr[W_A0];
          end
        end
        ST_DRAIN: begin
          if (w_empty) begin
            r_state <= ST_HALTED;
            r_halt  <= 1'b1;
          end
        end
        ST_HALTED: r_state <= ST_HALTED;
        default:   r_state <= ST_RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_commit_trace_buffer.sv
// tb/tb_commit_trace_buffer.sv - directed and randomized checks against a queue-based model
module tb_commit_trace_buffer;
  localparam int XLEN   = 64;
  localparam int NR_GPR = 32;
  localparam int DEPTH  = 8;

  typedef struct {
    logic [63:0] pc;
    logic [31:0] inst;
    logic        wen;
    logic [4:0]  rd;
    logic [63:0] wdata;
  } ent_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  commit_trace_buffer_if #(.XLEN(XLEN), .NR_GPR(NR_GPR)) bus ();

  commit_trace_buffer #(.XLEN(XLEN), .NR_GPR(NR_GPR), .DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  ent_t        m_q[$];
  logic [63:0] m_gpr [NR_GPR];
  logic [63:0] m_instret;
  logic [63:0] m_exit;
  bit          m_ovf;
  int          m_mode;  // 0 running, 1 draining, 2 halted
  int          n_tests = 0;
  int          n_fail  = 0;

  task automatic check(input string tag, input logic [191:0] got, input logic [191:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    for (int i = 0; i < NR_GPR; i++) m_gpr[i] = '0;
    m_instret = '0;
    m_exit    = '0;
    m_ovf     = 0;
    m_mode    = 0;
  endtask

  task automatic compare_all();
    check("trace_valid", bus.trace_valid, m_q.size() > 0);
    if (m_q.size() > 0) begin
      check("trace_pc", bus.trace_pc, m_q[0].pc);
      check("trace_inst", bus.trace_inst, m_q[0].inst);
      check("trace_wen_rd", {bus.trace_wen, bus.trace_rd}, {m_q[0].wen, m_q[0].rd});
      check("trace_wdata", bus.trace_wdata, m_q[0].wdata);
    end
    check("overflow", bus.overflow, m_ovf);
    check("halt", bus.halt, m_mode == 2);
    check("exit_code", bus.exit_code, m_exit);
    check("instret", bus.instret, m_instret);
    check("gpr_rdata", bus.gpr_rdata, m_gpr[bus.gpr_raddr]);
  endtask

  task automatic cycle(input bit r, input bit v, input logic [63:0] pc, input logic [31:0] inst,
                       input bit wen, input logic [4:0] rd, input logic [63:0] wd,
                       input bit brk, input bit rdy);
    int   sz;
    bit   pop;
    ent_t e;
    rst                 = r;
    bus.commit_valid    = v;
    bus.commit_pc       = pc;
    bus.commit_inst     = inst;
    bus.commit_rd_wen   = wen;
    bus.commit_rd       = rd;
    bus.commit_rd_wdata = wd;
    bus.commit_is_break = brk;
    bus.trace_ready     = rdy;
    bus.gpr_raddr       = 5'($urandom_range(0, NR_GPR - 1));
    @(posedge clk);
    if (r) begin
      model_reset();
    end else begin
      sz  = m_q.size();
      pop = (sz > 0) && rdy;
      if (pop) void'(m_q.pop_front());
      if (m_mode == 1 && sz == 0) m_mode = 2;
      else if (v && m_mode == 0) begin
        e = '{pc, inst, wen, rd, wd};
        if (sz == DEPTH && !pop) m_ovf = 1;
        else m_q.push_back(e);
        if (m_instret != 64'hFFFF_FFFF_FFFF_FFFF) m_instret++;
        if (brk) begin
          m_exit = m_gpr[10];
          m_mode = 1;
        end
        if (wen && rd != 0) m_gpr[rd] = wd;
      end
    end
    @(negedge clk);
    compare_all();
  endtask

  task automatic idle(input bit rdy);
    cycle(0, 0, '0, '0, 0, '0, '0, 0, rdy);
  endtask

  task automatic do_reset();
    cycle(1, 0, '0, '0, 0, '0, '0, 0, 0);
  endtask

  initial begin
    model_reset();
    do_reset();
    check("rst_valid", bus.trace_valid, 1'b0);
    check("rst_halt", bus.halt, 1'b0);
    check("rst_instret", bus.instret, 64'd0);

    // First commit visible on the trace port one cycle later.
    cycle(0, 1, 64'h8000_0000, 32'h0050_0513, 1, 5'd10, 64'd5, 0, 0);
    check("t1_pc", bus.trace_pc, 64'h8000_0000);
    bus.gpr_raddr = 5'd10;
    #1;
    check("t1_a0", bus.gpr_rdata, 64'd5);
    check("t1_instret", bus.instret, 64'd1);

    // Fill past capacity, then drain in order.
    do_reset();
    for (int i = 0; i < DEPTH + 1; i++)
      cycle(0, 1, 64'h1000 + 64'(4 * i), 32'($urandom), 1, 5'(i + 1), 64'(i * 3), 0, 0);
    check("ovf_set", bus.overflow, 1'b1);
    check("ovf_instret", bus.instret, 64'd9);
    for (int i = 0; i < DEPTH; i++) begin
      check("ovf_order", bus.trace_pc, 64'h1000 + 64'(4 * i));
      idle(1);
    end
    check("ovf_empty", bus.trace_valid, 1'b0);

    // Push and pop together while full.
    do_reset();
    for (int i = 0; i < DEPTH; i++) cycle(0, 1, 64'(i), '0, 0, '0, '0, 0, 0);
    cycle(0, 1, 64'h99, '0, 0, '0, '0, 0, 1);
    check("full_pp_ovf", bus.overflow, 1'b0);
    for (int i = 0; i < DEPTH; i++) idle(1);
    check("full_pp_empty", bus.trace_valid, 1'b0);

    // x0 write recorded in trace but never visible in the GPR file.
    do_reset();
    cycle(0, 1, 64'h44, '0, 1, 5'd0, 64'hFFFF, 0, 0);
    check("x0_wen_rd", {bus.trace_wen, bus.trace_rd}, 6'b1_00000);
    bus.gpr_raddr = 5'd0;
    #1;
    check("x0_read", bus.gpr_rdata, 64'd0);

    // ebreak with entries queued: drain, halt, ignore later commits.
    do_reset();
    cycle(0, 1, 64'h100, '0, 1, 5'd10, 64'h2A, 0, 0);
    cycle(0, 1, 64'h104, '0, 1, 5'd5, 64'h7, 0, 0);
    cycle(0, 1, 64'h108, '0, 0, 5'd0, 64'h0, 0, 0);
    cycle(0, 1, 64'h10C, 32'h0010_0073, 0, 5'd0, 64'h0, 1, 0);
    cycle(0, 1, 64'h110, '0, 1, 5'd10, 64'h55, 0, 0);
    check("brk_instret", bus.instret, 64'd4);
    check("brk_no_halt", bus.halt, 1'b0);
    begin
      int n = 0;
      while (!bus.halt && n < 20) begin
        cycle(0, 1, 64'h200, '0, 1, 5'd10, 64'h66, 0, 1);
        n++;
      end
      check("brk_halt_bound", n < 20, 1'b1);
    end
    check("brk_exit", bus.exit_code, 64'h2A);
    check("brk_instret2", bus.instret, 64'd4);

    // Reset in the middle of a drain.
    do_reset();
    cycle(0, 1, 64'h300, '0, 0, '0, '0, 0, 0);
    cycle(0, 1, 64'h304, '0, 0, '0, '0, 1, 0);
    do_reset();
    check("mid_rst_valid", bus.trace_valid, 1'b0);
    check("mid_rst_instret", bus.instret, 64'd0);
    cycle(0, 1, 64'h400, '0, 1, 5'd3, 64'h9, 0, 0);
    check("mid_rst_accept", bus.trace_pc, 64'h400);
    check("mid_rst_instret1", bus.instret, 64'd1);

    // Randomized traffic, including occasional ebreaks and resets.
    do_reset();
    for (int c = 0; c < 800; c++) begin
      bit r, v, rdy, brk;
      r   = ($urandom_range(0, 299) == 0) || (m_mode == 2 && $urandom_range(0, 7) == 0);
      rdy = ((c / 40) % 2 == 1) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
      v   = $urandom_range(0, 2) != 0;
      brk = $urandom_range(0, 79) == 0;
      cycle(r, v, {$urandom, $urandom}, $urandom, 1'($urandom_range(0, 1)),
            5'($urandom_range(0, 31)), {$urandom, $urandom}, brk, rdy);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
